// File: rtl/alu_logic_sequencer_pkg.sv
// Shared definitions for the ALU bitwise-logic sequencer.
//   op encodings : OP_AND / OP_OR / OP_XOR / OP_NOR (2 bits)
//   FSM states   : S_IDLE / S_RUN / S_DONE (2 bits)
//   idx_width()  : width of a slice counter, never narrower than one bit
package alu_logic_sequencer_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // A single-slice configuration still needs a 1-bit counter to keep the
  // declarations legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_logic_sequencer_logic_slice.sv
// Combinational SLICE-bit bitwise-logic evaluator.
//   op : 2-bit operation select (AND/OR/XOR/NOR)
//   a  : SLICE-bit operand A slice
//   b  : SLICE-bit operand B slice
//   y  : SLICE-bit result slice
module logic_slice
  import alu_logic_sequencer_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [1:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  logic [SLICE-1:0] y_and;
  logic [SLICE-1:0] y_or;
  logic [SLICE-1:0] y_xor;
  logic [SLICE-1:0] y_nor;

  // One gate of each kind per bit; the op only steers the output mux.
  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    and u_and (y_and[i], a[i], b[i]);
    or  u_or  (y_or[i],  a[i], b[i]);
    xor u_xor (y_xor[i], a[i], b[i]);
    nor u_nor (y_nor[i], a[i], b[i]);
  end

  always_comb begin
    y = y_and;
    case (op)
      OP_AND:  y = y_and;
      OP_OR:   y = y_or;
      OP_XOR:  y = y_xor;
      OP_NOR:  y = y_nor;
      default: y = y_and;
    endcase
  end

endmodule

// File: rtl/alu_logic_sequencer.sv
// Slice-serial bitwise-logic sequencer between the multicycle control FSM and
// register-file writeback. One WIDTH-bit request is evaluated SLICE bits per
// clock; the assembled result and zero flag are held until consumed.
//   clk, reset_n          : clock, synchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_op, req_a, req_b  : operation and operands, latched at accept
//   rsp_valid/rsp_ready   : response handshake (valid only in DONE)
//   rsp_result, rsp_zero  : registered result and result==0 flag
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready=1
// S_RUN  | evaluating one slice per edge, slice_idx 0..NSLICE-1
// S_DONE | result held, rsp_valid=1 until rsp_ready
module alu_logic_sequencer
  import alu_logic_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = idx_width(NSLICE);

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("alu_logic_sequencer: WIDTH must be a multiple of SLICE");
  end

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  slice_idx;
  logic             zero_acc;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] y_sl;
  logic             last_slice;
  logic             y_zero;
  int               sel_lo;

  always_comb begin
    sel_lo = int'(slice_idx) * SLICE;
    a_sl   = a_q[sel_lo +: SLICE];
    b_sl   = b_q[sel_lo +: SLICE];
  end

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .op (op_q),
    .a  (a_sl),
    .b  (b_sl),
    .y  (y_sl)
  );

  assign last_slice = (slice_idx == IDXW'(NSLICE - 1));
  assign y_zero     = (y_sl == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      slice_idx <= '0;
      zero_acc  <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            a_q       <= req_a;
            b_q       <= req_b;
            slice_idx <= '0;
            zero_acc  <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          result_q[sel_lo +: SLICE] <= y_sl;
          zero_acc                  <= zero_acc & y_zero;
          // Counter parks at NSLICE-1 instead of wrapping; IDLE re-arms it.
          if (last_slice) begin
            zero_q <= zero_acc & y_zero;
            state  <= S_DONE;
          end else begin
            slice_idx <= slice_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign rsp_valid  = (state == S_DONE);
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule
